l1_d_cache: RTL and testbench

Level-1 data cache between the pipeline memory stage and the shared last-level cache. It is direct-mapped, write-back and write-allocate, with 64-byte lines. It serves 64-bit loads and 1/2/4/8-byte stores from the core, fills and evicts whole 512-bit lines over the LLC port, and invalidates lines on bus snoops.

---
 rtl/l1_d_cache.sv | 201 ++++++++++++++++++++
 tb/tb_l1_d_cache.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_d_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 64-byte lines.
// Serves one load or store at a time; fills/evicts whole lines over the LLC port and honours invalidating snoops.
module l1_d_cache #(
   parameter int NUM_SETS = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [63:0]  S_R_ADDR,
   input  logic         S_R_ADDR_VALID,
   output logic [63:0]  S_R_DATA,
   output logic         S_R_DATA_VALID,
   input  logic         S_W_VALID,
   input  logic [63:0]  S_W_ADDR,
   input  logic [63:0]  S_W_DATA,
   input  logic [3:0]   S_W_SIZE,
   output logic         S_W_READY,
   output logic         S_W_COMPLETE,
   output logic [63:0]  L2_S_R_ADDR,
   output logic         L2_S_R_ADDR_VALID,
   input  logic [511:0] L2_S_R_DATA,
   input  logic         L2_S_R_DATA_VALID,
   output logic         L2_S_W_VALID,
   output logic [63:0]  L2_S_W_ADDR,
   output logic [511:0] L2_S_W_DATA,
   input  logic         L2_S_W_READY,
   input  logic         L2_S_W_COMPLETE,
   input  logic         m_axi_acvalid,
   input  logic [63:0]  m_axi_acaddr,
   input  logic [3:0]   m_axi_acsnoop,
   output logic [1:0]   o_dbg_state
);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 58 - IDX_W;

   typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, RESP = 2'd3} state_t;
   state_t r_state, w_next;

   logic             r_valid [NUM_SETS];
   logic             r_dirty [NUM_SETS];
   logic [TAG_W-1:0] r_tag   [NUM_SETS];
   logic [511:0]     r_data  [NUM_SETS];

   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [3:0]  r_size;
   logic        r_is_store;
   logic        r_wb_acc;

   logic [63:0]      w_req_addr;
   logic             w_req;
   logic [IDX_W-1:0] w_in_idx, w_idx, w_snp_idx;
   logic [TAG_W-1:0] w_in_tag, w_tag, w_snp_tag;
   logic [5:0]       w_off;
   logic             w_hit, w_victim_dirty, w_snp_hit;
   logic [511:0]     w_line, w_rd_shift, w_wshift, w_merged;
   logic [7:0]       w_size_mask;
   logic [63:0]      w_bmask;
   logic             w_unused;

   // Store wins when both requests are present; the load stays held and is taken next.
   assign w_req      = S_W_VALID | S_R_ADDR_VALID;
   assign w_req_addr = S_W_VALID ? S_W_ADDR : S_R_ADDR;
   assign w_in_idx   = w_req_addr[6 +: IDX_W];
   assign w_in_tag   = w_req_addr[63 -: TAG_W];
   assign w_hit          = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
   assign w_victim_dirty = r_valid[w_in_idx] && r_dirty[w_in_idx];

   assign w_idx  = r_addr[6 +: IDX_W];
   assign w_tag  = r_addr[63 -: TAG_W];
   assign w_off  = r_addr[5:0];
   assign w_line = r_data[w_idx];

   assign w_snp_idx = m_axi_acaddr[6 +: IDX_W];
   assign w_snp_tag = m_axi_acaddr[63 -: TAG_W];
   assign w_snp_hit = m_axi_acvalid && (m_axi_acsnoop == 4'hD) &&
                      r_valid[w_snp_idx] && (r_tag[w_snp_idx] == w_snp_tag);
   assign w_unused  = ^m_axi_acaddr[5:0];

   // Right shift zero-fills, so load bytes beyond the end of the line read as 0.
   assign w_rd_shift = w_line >> {w_off, 3'b000};
   assign w_wshift   = 512'(r_wdata) << {w_off, 3'b000};
   assign w_bmask    = 64'(w_size_mask) << w_off;

   always_comb begin
      w_size_mask = 8'h00;
      case (r_size)
         4'd1:    w_size_mask = 8'h01;
         4'd2:    w_size_mask = 8'h03;
         4'd4:    w_size_mask = 8'h0F;
         4'd8:    w_size_mask = 8'hFF;
         default: w_size_mask = 8'h00;
      endcase
   end

   always_comb begin
      w_merged = w_line;
      for (int i = 0; i < 64; i++) begin
         if (w_bmask[i]) w_merged[8*i +: 8] = w_wshift[8*i +: 8];
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_req) w_next = w_hit ? RESP : (w_victim_dirty ? WB : FILL);
         WB:   if (L2_S_W_COMPLETE) w_next = FILL;
         FILL: if (L2_S_R_DATA_VALID) w_next = RESP;
         RESP: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      S_R_DATA          = '0;
      S_R_DATA_VALID    = 1'b0;
      S_W_READY         = 1'b0;
      S_W_COMPLETE      = 1'b0;
      L2_S_R_ADDR       = '0;
      L2_S_R_ADDR_VALID = 1'b0;
      L2_S_W_VALID      = 1'b0;
      L2_S_W_ADDR       = '0;
      L2_S_W_DATA       = '0;
      o_dbg_state       = 2'b00;
      if (reset) begin
         o_dbg_state = r_state;
         case (r_state)
            IDLE: S_W_READY = 1'b1;
            WB: begin
               L2_S_W_VALID = !r_wb_acc;
               L2_S_W_ADDR  = {r_tag[w_idx], w_idx, 6'b000000};
               L2_S_W_DATA  = w_line;
            end
            FILL: begin
               L2_S_R_ADDR       = {r_addr[63:6], 6'b000000};
               L2_S_R_ADDR_VALID = 1'b1;
            end
            RESP: begin
               if (r_is_store) begin
                  S_W_COMPLETE = 1'b1;
               end else begin
                  S_R_DATA_VALID = 1'b1;
                  S_R_DATA       = w_rd_shift[63:0];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_size     <= '0;
         r_is_store <= 1'b0;
         r_wb_acc   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_req) begin
            r_addr     <= w_req_addr;
            r_wdata    <= S_W_DATA;
            r_size     <= S_W_SIZE;
            r_is_store <= S_W_VALID;
         end
         if (r_state == WB) begin
            if (L2_S_W_COMPLETE)   r_wb_acc <= 1'b0;
            else if (L2_S_W_READY) r_wb_acc <= 1'b1;
         end
      end
   end

   // Write order sets priority: merge dirty, then snoop invalidate, then fill install wins.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SETS; i++) begin
            r_valid[i] <= 1'b0;
            r_dirty[i] <= 1'b0;
         end
      end else begin
         if (r_state == WB && L2_S_W_COMPLETE) r_dirty[w_idx] <= 1'b0;
         if (r_state == RESP && r_is_store)    r_dirty[w_idx] <= 1'b1;
         if (w_snp_hit) begin
            r_valid[w_snp_idx] <= 1'b0;
            r_dirty[w_snp_idx] <= 1'b0;
         end
         if (r_state == FILL && L2_S_R_DATA_VALID) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_tag[w_idx]   <= w_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if (r_state == FILL && L2_S_R_DATA_VALID) r_data[w_idx] <= L2_S_R_DATA;
         else if (r_state == RESP && r_is_store)   r_data[w_idx] <= w_merged;
      end
   end
endmodule

// File: tb/tb_l1_d_cache.sv
// Self-checking bench for l1_d_cache: directed scenarios plus randomized loads/stores/snoops
// compared against a line-level cache model and an LLC backing store held in the bench.
module tb_l1_d_cache;
   localparam int NS = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic [63:0]  S_R_ADDR;
   logic         S_R_ADDR_VALID;
   logic [63:0]  S_R_DATA;
   logic         S_R_DATA_VALID;
   logic         S_W_VALID;
   logic [63:0]  S_W_ADDR;
   logic [63:0]  S_W_DATA;
   logic [3:0]   S_W_SIZE;
   logic         S_W_READY;
   logic         S_W_COMPLETE;
   logic [63:0]  L2_S_R_ADDR;
   logic         L2_S_R_ADDR_VALID;
   logic [511:0] L2_S_R_DATA;
   logic         L2_S_R_DATA_VALID;
   logic         L2_S_W_VALID;
   logic [63:0]  L2_S_W_ADDR;
   logic [511:0] L2_S_W_DATA;
   logic         L2_S_W_READY;
   logic         L2_S_W_COMPLETE;
   logic         m_axi_acvalid;
   logic [63:0]  m_axi_acaddr;
   logic [3:0]   m_axi_acsnoop;
   logic [1:0]   o_dbg_state;

   always #5 clk = ~clk;

   l1_d_cache #(.NUM_SETS(NS)) dut (
      .clk(clk), .reset(reset),
      .S_R_ADDR(S_R_ADDR), .S_R_ADDR_VALID(S_R_ADDR_VALID),
      .S_R_DATA(S_R_DATA), .S_R_DATA_VALID(S_R_DATA_VALID),
      .S_W_VALID(S_W_VALID), .S_W_ADDR(S_W_ADDR), .S_W_DATA(S_W_DATA), .S_W_SIZE(S_W_SIZE),
      .S_W_READY(S_W_READY), .S_W_COMPLETE(S_W_COMPLETE),
      .L2_S_R_ADDR(L2_S_R_ADDR), .L2_S_R_ADDR_VALID(L2_S_R_ADDR_VALID),
      .L2_S_R_DATA(L2_S_R_DATA), .L2_S_R_DATA_VALID(L2_S_R_DATA_VALID),
      .L2_S_W_VALID(L2_S_W_VALID), .L2_S_W_ADDR(L2_S_W_ADDR), .L2_S_W_DATA(L2_S_W_DATA),
      .L2_S_W_READY(L2_S_W_READY), .L2_S_W_COMPLETE(L2_S_W_COMPLETE),
      .m_axi_acvalid(m_axi_acvalid), .m_axi_acaddr(m_axi_acaddr), .m_axi_acsnoop(m_axi_acsnoop),
      .o_dbg_state(o_dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: per-set line copy plus the LLC contents keyed by line address.
   logic         m_valid [NS];
   logic         m_dirty [NS];
   logic [57:0]  m_la    [NS];
   logic [511:0] m_line  [NS];
   logic [511:0] mem [logic [57:0]];

   function automatic logic [511:0] gen_line(input logic [57:0] la);
      logic [511:0] l;
      for (int i = 0; i < 64; i++) l[8*i +: 8] = la[7:0] ^ la[15:8] ^ 8'(i * 37 + 11);
      return l;
   endfunction

   function automatic logic [511:0] mem_get(input logic [57:0] la);
      if (mem.exists(la)) return mem[la];
      return gen_line(la);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endtask

   task automatic model_access(input bit st, input logic [63:0] a, input logic [63:0] d, input int sz,
                               output bit hit, output bit wb, output logic [63:0] wb_a,
                               output logic [511:0] wb_d, output logic [63:0] rd);
      logic [57:0] la;
      int set, off;
      la  = a[63:6];
      set = int'(la % 58'(NS));
      off = int'(a[5:0]);
      hit = m_valid[set] && (m_la[set] == la);
      wb  = !hit && m_valid[set] && m_dirty[set];
      wb_a = {m_la[set], 6'b0};
      wb_d = m_line[set];
      if (wb) mem[m_la[set]] = m_line[set];
      if (!hit) begin
         m_valid[set] = 1'b1;
         m_dirty[set] = 1'b0;
         m_la[set]    = la;
         m_line[set]  = mem_get(la);
      end
      rd = '0;
      if (st) begin
         for (int b = 0; b < sz; b++)
            if (off + b < 64) m_line[set][8*(off+b) +: 8] = d[8*b +: 8];
         m_dirty[set] = 1'b1;
      end else begin
         for (int b = 0; b < 8; b++)
            if (off + b < 64) rd[8*b +: 8] = m_line[set][8*(off+b) +: 8];
      end
   endtask

   task automatic model_snoop(input logic [63:0] a, input logic [3:0] typ);
      logic [57:0] la;
      int set;
      la  = a[63:6];
      set = int'(la % 58'(NS));
      if (typ == 4'hD && m_valid[set] && m_la[set] == la) begin
         m_valid[set] = 1'b0;
         m_dirty[set] = 1'b0;
      end
   endtask

   logic [63:0]  last_rdata;
   logic [63:0]  last_fill_addr;
   logic [63:0]  last_wb_addr;
   logic [511:0] last_wb_data;
   int           last_fill_cnt;
   int           last_wb_cnt;

   task automatic clear_inputs();
      S_R_ADDR = '0; S_R_ADDR_VALID = 1'b0;
      S_W_VALID = 1'b0; S_W_ADDR = '0; S_W_DATA = '0; S_W_SIZE = '0;
      L2_S_R_DATA = '0; L2_S_R_DATA_VALID = 1'b0;
      L2_S_W_READY = 1'b0; L2_S_W_COMPLETE = 1'b0;
      m_axi_acvalid = 1'b0; m_axi_acaddr = '0; m_axi_acsnoop = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      repeat (2) begin
         @(negedge clk);
         chk("rst_ctl", {S_R_DATA_VALID, S_W_READY, S_W_COMPLETE, L2_S_R_ADDR_VALID, L2_S_W_VALID, o_dbg_state}, '0);
         chk("rst_bus", S_R_DATA | L2_S_R_ADDR | L2_S_W_ADDR, '0);
         chk("rst_wdata", L2_S_W_DATA, '0);
      end
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      chk("ready_after_rst", S_W_READY, 1);
   endtask

   task automatic snoop(input logic [63:0] a, input logic [3:0] typ);
      m_axi_acvalid = 1'b1; m_axi_acaddr = a; m_axi_acsnoop = typ;
      model_snoop(a, typ);
      @(negedge clk);
      m_axi_acvalid = 1'b0;
   endtask

   // smode: 0 none, 1 invalidating snoop on the fill-capture edge, 2 on the store-merge edge.
   task automatic run_op(input string nm, input bit st, input logic [63:0] sa, input logic [63:0] sd,
                         input logic [3:0] ssz, input bit ld, input logic [63:0] la_in, input int smode);
      bit e_hit, e_wb, h2, w2;
      logic [63:0] e_wba, e_rd, dummy, w2a, op_addr;
      logic [511:0] e_wbd, w2d;
      int exp_fills, exp_wbs, c, st_cnt, ld_cnt, st_lat, ld_lat;
      int fill_cnt, fill_lat, data_lat, wb_cnt, comp_lat, fill_wait, comp_wait;
      bit fill_act, wb_acc, wb_prev, wb_bad, single;
      logic [63:0] fill_addr, wb_addr, rdata;
      logic [511:0] wb_data;
      exp_fills = 0; exp_wbs = 0; c = 0; st_cnt = 0; ld_cnt = 0; st_lat = 0; ld_lat = 0;
      fill_cnt = 0; fill_lat = 0; data_lat = 0; wb_cnt = 0; comp_lat = 0; fill_wait = -1; comp_wait = -1;
      fill_act = 0; wb_acc = 0; wb_prev = 0; wb_bad = 0; fill_addr = '0; wb_addr = '0; rdata = '0; wb_data = '0;
      e_rd = '0; e_hit = 0; e_wb = 0; e_wba = '0; e_wbd = '0;
      single = !(st && ld);
      op_addr = st ? sa : la_in;
      if (st) begin
         model_access(1'b1, sa, sd, int'(ssz), e_hit, e_wb, e_wba, e_wbd, dummy);
         exp_fills += int'(!e_hit); exp_wbs += int'(e_wb);
         if (smode == 2) model_snoop(sa, 4'hD);
      end
      if (ld) begin
         model_access(1'b0, la_in, '0, 0, h2, w2, w2a, w2d, e_rd);
         exp_fills += int'(!h2); exp_wbs += int'(w2);
         if (!st) begin e_hit = h2; e_wb = w2; e_wba = w2a; e_wbd = w2d; end
      end
      S_W_VALID = st; S_W_ADDR = sa; S_W_DATA = sd; S_W_SIZE = ssz;
      S_R_ADDR_VALID = ld; S_R_ADDR = la_in;
      while (((st && st_cnt == 0) || (ld && ld_cnt == 0)) && c < 300) begin
         @(negedge clk);
         c++;
         L2_S_R_DATA_VALID = 1'b0; L2_S_W_COMPLETE = 1'b0; m_axi_acvalid = 1'b0;
         if (wb_prev && L2_S_W_READY && !wb_acc) begin
            wb_acc = 1; comp_wait = $urandom_range(0, 2);
         end
         if (L2_S_W_VALID) begin
            if (wb_cnt == 0) begin wb_cnt = 1; wb_addr = L2_S_W_ADDR; wb_data = L2_S_W_DATA; end
            else if (L2_S_W_ADDR !== wb_addr || L2_S_W_DATA !== wb_data) wb_bad = 1;
            if (wb_acc) wb_bad = 1;
         end
         if (wb_acc && comp_wait >= 0) begin
            if (comp_wait == 0) begin L2_S_W_COMPLETE = 1'b1; comp_lat = c; end
            comp_wait--;
         end
         L2_S_W_READY = (L2_S_W_VALID && !wb_acc) ? 1'($urandom_range(0, 1)) : 1'b0;
         wb_prev = L2_S_W_VALID;
         if (L2_S_R_ADDR_VALID) begin
            if (!fill_act) begin
               fill_act = 1; fill_cnt++; fill_addr = L2_S_R_ADDR; fill_lat = c;
               fill_wait = $urandom_range(0, 3);
            end
            if (fill_wait == 0) begin
               L2_S_R_DATA = mem_get(L2_S_R_ADDR[63:6]); L2_S_R_DATA_VALID = 1'b1; data_lat = c;
               if (smode == 1) begin m_axi_acvalid = 1'b1; m_axi_acaddr = op_addr; m_axi_acsnoop = 4'hD; end
            end
            if (fill_wait >= 0) fill_wait--;
         end else begin
            fill_act = 0;
         end
         if (S_W_COMPLETE) begin
            st_cnt++; st_lat = c; S_W_VALID = 1'b0;
            if (smode == 2) begin m_axi_acvalid = 1'b1; m_axi_acaddr = sa; m_axi_acsnoop = 4'hD; end
         end
         if (S_R_DATA_VALID) begin
            ld_cnt++; ld_lat = c; rdata = S_R_DATA; S_R_ADDR_VALID = 1'b0;
         end
      end
      chk({nm, "_finished"}, ((st_cnt > 0) || !st) && ((ld_cnt > 0) || !ld), 1);
      @(negedge clk);
      clear_inputs();
      chk({nm, "_one_pulse"}, {S_W_COMPLETE, S_R_DATA_VALID}, 0);
      chk({nm, "_idle_ready"}, S_W_READY, 1);
      chk({nm, "_st_cnt"}, st_cnt, st);
      chk({nm, "_ld_cnt"}, ld_cnt, ld);
      chk({nm, "_fills"}, fill_cnt, exp_fills);
      chk({nm, "_wbs"}, wb_cnt, exp_wbs);
      if (single && e_wb) begin
         chk({nm, "_wb_addr"}, wb_addr, e_wba);
         chk({nm, "_wb_data"}, wb_data, e_wbd);
         chk({nm, "_wb_stable"}, wb_bad, 0);
         chk({nm, "_fill_after_wb"}, fill_lat, comp_lat + 1);
      end
      if (single && e_hit) chk({nm, "_hit_lat"}, st ? st_lat : ld_lat, 1);
      if (single && !e_hit) begin
         chk({nm, "_fill_addr"}, fill_addr, {op_addr[63:6], 6'b0});
         if (!e_wb) chk({nm, "_fill_lat"}, fill_lat, 1);
         chk({nm, "_resp_lat"}, st ? st_lat : ld_lat, data_lat + 1);
      end
      if (!single) chk({nm, "_store_first"}, st_lat < ld_lat, 1);
      if (ld) chk({nm, "_rdata"}, rdata, e_rd);
      last_rdata = rdata; last_fill_addr = fill_addr; last_wb_addr = wb_addr;
      last_wb_data = wb_data; last_fill_cnt = fill_cnt; last_wb_cnt = wb_cnt;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] l0, merged;
      logic [63:0] a, d;
      int sz, off, kind, cnt;

      clear_inputs();
      do_reset();

      for (int i = 0; i < 64; i++) l0[8*i +: 8] = 8'(i);
      mem[58'h40] = l0;

      run_op("tp_load_miss", 0, '0, '0, '0, 1, 64'h1000, 0);
      chk("tp_fill_addr_1000", last_fill_addr, 64'h1000);
      chk("tp_load_1000", last_rdata, 64'h0706050403020100);
      run_op("tp_load_hit", 0, '0, '0, '0, 1, 64'h1008, 0);
      chk("tp_load_1008", last_rdata, 64'h0F0E0D0C0B0A0908);

      run_op("tp_store_hit", 1, 64'h1004, 64'hBEEF, 4'd2, 0, '0, 0);
      run_op("tp_load_merged", 0, '0, '0, '0, 1, 64'h1000, 0);
      chk("tp_merged_1000", last_rdata, 64'h0706BEEF03020100);

      merged = l0;
      merged[39:32] = 8'hEF;
      merged[47:40] = 8'hBE;
      run_op("tp_evict", 0, '0, '0, '0, 1, 64'h1000 + 64 * NS, 0);
      chk("tp_evict_addr", last_wb_addr, 64'h1000);
      chk("tp_evict_data", last_wb_data, merged);
      chk("tp_evict_fill", last_fill_addr, 64'h2000);

      run_op("tp_dirty_again", 1, 64'h1000, 64'h1122334455667788, 4'd8, 0, '0, 0);
      snoop(64'h1010, 4'hD);
      run_op("tp_after_snoop", 0, '0, '0, '0, 1, 64'h1000, 0);
      chk("tp_snoop_refill", last_fill_cnt, 1);
      chk("tp_snoop_no_wb", last_wb_cnt, 0);
      snoop(64'h1000, 4'h0);
      run_op("tp_snoop_ignored", 0, '0, '0, '0, 1, 64'h1008, 0);
      chk("tp_snoop0_kept", last_fill_cnt, 0);

      run_op("tp_store_miss", 1, 64'h2003, 64'hAA, 4'd1, 0, '0, 0);
      run_op("tp_load_2000", 0, '0, '0, '0, 1, 64'h2000, 0);
      chk("tp_byte3", last_rdata[31:24], 8'hAA);

      run_op("tp_dual", 1, 64'h2010, 64'hCAFEF00D, 4'd4, 1, 64'h2010, 0);
      chk("tp_dual_data", last_rdata[31:0], 32'hCAFEF00D);

      run_op("snp_on_merge", 1, 64'h2020, 64'h0123456789ABCDEF, 4'd8, 0, '0, 2);
      run_op("snp_merge_chk", 0, '0, '0, '0, 1, 64'h2020, 0);
      chk("snp_merge_miss", last_fill_cnt, 1);
      run_op("snp_on_fill", 1, 64'h3048, 64'hFEEDFACE00C0FFEE, 4'd8, 0, '0, 1);
      run_op("snp_fill_chk", 0, '0, '0, '0, 1, 64'h3048, 0);
      chk("snp_fill_kept", last_fill_cnt, 0);

      run_op("line_end", 0, '0, '0, '0, 1, 64'h107C, 0);
      chk("line_end_zero", last_rdata[63:32], 32'h0);

      // Abandon a miss with reset and confirm the LLC port stays quiet afterwards.
      S_R_ADDR = 64'hABC000; S_R_ADDR_VALID = 1'b1;
      cnt = 0;
      while (!(L2_S_R_ADDR_VALID || L2_S_W_VALID) && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("midmiss_l2_req", L2_S_R_ADDR_VALID | L2_S_W_VALID, 1);
      reset = 1'b0;
      clear_inputs();
      @(negedge clk);
      chk("midmiss_rst_out", {S_R_DATA_VALID, S_W_READY, S_W_COMPLETE, L2_S_R_ADDR_VALID, L2_S_W_VALID}, 0);
      reset = 1'b1;
      model_reset();
      repeat (4) begin
         @(negedge clk);
         chk("midmiss_quiet", {L2_S_R_ADDR_VALID, L2_S_W_VALID, S_R_DATA_VALID, S_W_COMPLETE, S_W_READY}, 5'b00001);
      end

      for (int k = 0; k < 80; k++) begin
         a    = 64'h40000 + 64'(($urandom_range(0, 3) * NS + $urandom_range(0, 3)) * 64);
         kind = $urandom_range(0, 9);
         sz   = 1 << $urandom_range(0, 3);
         off  = $urandom_range(0, 63);
         d    = {$urandom, $urandom};
         if (kind < 4) begin
            off = off & ~(sz - 1);
            run_op("rnd_st", 1, a + 64'(off), d, 4'(sz), 0, '0,
                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
         end else if (kind < 9) begin
            run_op("rnd_ld", 0, '0, '0, '0, 1, a + 64'(off), 0);
         end else begin
            snoop(a + 64'(off), ($urandom_range(0, 1) == 0) ? 4'hD : 4'h0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
